// File: rtl/encoder_8_3_serial.sv
// Serial priority encoder: accepts a multi-hot request vector and emits the index of
// each set bit, lowest first, one per downstream handshake.
module encoder_8_3_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] Y,
  output logic       Y_valid,
  input  logic       Y_ready,
  output logic       last,
  output logic [3:0] count,
  output logic       zero
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [7:0] r_pending;
  logic [7:0] w_pending_d;
  logic       r_zero;
  logic       w_zero_d;
  logic [2:0] w_low_idx;
  logic [3:0] w_popcnt;
  logic       w_accept;
  logic       w_xfer;

  // Lowest set bit wins; iterate high-to-low so the last assignment is the lowest.
  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = 3'(i);
    end
  end

  always_comb begin
    w_popcnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_popcnt = w_popcnt + 4'(r_pending[i]);
    end
  end

  assign in_ready = (r_state == StIdle);
  assign Y_valid  = (r_state == StEmit);
  assign Y        = w_low_idx;
  assign last     = Y_valid && (w_popcnt == 4'd1);
  assign count    = Y_valid ? w_popcnt : 4'd0;
  assign zero     = r_zero;

  assign w_accept = in_ready && in_valid;
  assign w_xfer   = Y_valid && Y_ready;

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending;
    w_zero_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_pending_d = A;
          if (A == 8'd0) begin
            w_zero_d = 1'b1;
          end else begin
            w_state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (w_xfer) begin
          w_pending_d = r_pending & ~(8'd1 << w_low_idx);
          if (last) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pending <= 8'd0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_zero    <= w_zero_d;
    end
  end

endmodule

// File: tb/tb_encoder_8_3_serial.sv
// Scoreboard bench for encoder_8_3_serial: stimulus pushes expected transfers,
// a negedge monitor pops and compares on every handshake.
module tb_encoder_8_3_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] Y;
  logic       Y_valid;
  logic       Y_ready;
  logic       last;
  logic [3:0] count;
  logic       zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] y;
    logic       last;
    logic [3:0] count;
  } exp_t;

  exp_t exp_q[$];

  encoder_8_3_serial dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Y        (Y),
    .Y_valid  (Y_valid),
    .Y_ready  (Y_ready),
    .last     (last),
    .count    (count),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] y, input logic l, input logic [3:0] c);
    exp_t e;
    e.y = y;
    e.last = l;
    e.count = c;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [7:0] a);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_wait: in_ready never rose");
    end
    A = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      errors++;
      $display("FAIL %s_drain: %0d transfers left, in_ready=%0b", name, exp_q.size(), in_ready);
      exp_q.delete();
    end
  endtask

  // Monitor: pop on handshake, and verify outputs hold while stalled.
  logic       hold_prev = 1'b0;
  logic [2:0] hold_y;
  logic       hold_last;
  logic [3:0] hold_count;

  always @(negedge clk) begin
    if (hold_prev && Y_valid) begin
      check("hold_y", 8'(Y), 8'(hold_y));
      check("hold_last", 8'(last), 8'(hold_last));
      check("hold_count", 8'(count), 8'(hold_count));
    end
    if (Y_valid && Y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got Y=%0d with nothing expected", Y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("xfer_y", 8'(Y), 8'(e.y));
        check("xfer_last", 8'(last), 8'(e.last));
        check("xfer_count", 8'(count), 8'(e.count));
      end
    end
    hold_prev  = Y_valid && !Y_ready;
    hold_y     = Y;
    hold_last  = last;
    hold_count = count;
  end

  initial begin
    rst = 1'b1;
    A = 8'h00;
    in_valid = 1'b1;
    Y_ready = 1'b1;
    tick();
    tick();
    // rst has priority over a pending accept
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_y_valid", 8'(Y_valid), 8'd0);
    check("rst_y", 8'(Y), 8'd0);
    check("rst_last", 8'(last), 8'd0);
    check("rst_count", 8'(count), 8'd0);
    check("rst_zero", 8'(zero), 8'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single bit
    push(3'd0, 1'b1, 4'd1);
    accept(8'b0000_0001);
    check("single_y_valid", 8'(Y_valid), 8'd1);
    drain("single");
    check("single_idle_y_valid", 8'(Y_valid), 8'd0);

    // Multi-hot
    push(3'd2, 1'b0, 4'd3);
    push(3'd5, 1'b0, 4'd2);
    push(3'd7, 1'b1, 4'd1);
    accept(8'b1010_0100);
    drain("multi");

    // Backpressure
    Y_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(3'(i), i == 7, 4'(8 - i));
    accept(8'hFF);
    for (int i = 0; i < 3; i++) begin
      check("bp_y", 8'(Y), 8'd0);
      check("bp_count", 8'(count), 8'd8);
      tick();
    end
    Y_ready = 1'b1;
    drain("bp");

    // Zero vector
    accept(8'h00);
    check("zero_pulse", 8'(zero), 8'd1);
    check("zero_y_valid", 8'(Y_valid), 8'd0);
    check("zero_in_ready", 8'(in_ready), 8'd1);
    tick();
    check("zero_cleared", 8'(zero), 8'd0);
    check("zero_y_valid2", 8'(Y_valid), 8'd0);

    // Reset mid-burst
    push(3'd0, 1'b0, 4'd8);
    push(3'd1, 1'b0, 4'd7);
    accept(8'hFF);
    tick();
    tick();
    Y_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    Y_ready = 1'b1;
    check("mid_rst_y_valid", 8'(Y_valid), 8'd0);
    check("mid_rst_count", 8'(count), 8'd0);
    check("mid_rst_in_ready", 8'(in_ready), 8'd1);
    repeat (5) tick();
    drain("mid_rst");

    // Input isolation: new A held valid during EMIT is taken only after returning to IDLE
    push(3'd0, 1'b0, 4'd2);
    push(3'd7, 1'b1, 4'd1);
    for (int i = 0; i < 8; i++) push(3'(i), i == 7, 4'(8 - i));
    accept(8'h81);
    A = 8'hFF;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !in_ready; n++) tick();
    tick();
    in_valid = 1'b0;
    drain("iso");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
